hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand forwarding select, load-use bubble sequencing,
// memory-miss freeze, deferred branch flush and saturating statistics.
//
// Ports:
//   clk, rst               clock, async active-high reset
//   rs1/rs2_id_ex          EX source regs (forwarding)
//   rs1/rs2_if_id, uses_*  ID source regs and their use flags (load-use)
//   rd_id_ex, is_load_id_ex EX destination and load flag
//   rd_fwd, load_regfile_fwd per-stage destination / write enable
//   inst_mem_*, data_mem_* memory request/response handshakes
//   br_taken_ex            EX redirects the PC
//   stat_clear             synchronous clear of statistics
//   rs1mux_sel/rs2mux_sel  0 = regfile, k+1 = forward from stage k
//   stall_*, bubble_id_ex, flush_*  pipeline register controls
//   stall_cnt/bubble_cnt/flush_cnt  saturating statistics
module hazard_ctrl #(
    parameter int NUM_FWD          = 2,
    parameter int REG_W            = 5,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int CNT_W            = 32,
    parameter int SEL_W            = $clog2(NUM_FWD + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_W-1:0]         rs1_id_ex,
    input  logic [REG_W-1:0]         rs2_id_ex,
    input  logic [REG_W-1:0]         rs1_if_id,
    input  logic [REG_W-1:0]         rs2_if_id,
    input  logic                     uses_rs1_if_id,
    input  logic                     uses_rs2_if_id,
    input  logic [REG_W-1:0]         rd_id_ex,
    input  logic                     is_load_id_ex,
    input  logic [NUM_FWD*REG_W-1:0] rd_fwd,
    input  logic [NUM_FWD-1:0]       load_regfile_fwd,
    input  logic                     inst_mem_read,
    input  logic                     inst_mem_resp,
    input  logic                     data_mem_read,
    input  logic                     data_mem_write,
    input  logic                     data_mem_resp,
    input  logic                     br_taken_ex,
    input  logic                     stat_clear,
    output logic [SEL_W-1:0]         rs1mux_sel,
    output logic [SEL_W-1:0]         rs2mux_sel,
    output logic                     stall_pc,
    output logic                     stall_if_id,
    output logic                     stall_id_ex,
    output logic                     stall_ex_mem,
    output logic                     stall_mem_wb,
    output logic                     bubble_id_ex,
    output logic                     flush_if_id,
    output logic                     flush_id_ex,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         bubble_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_PEND = 1'b1;
    localparam logic [2:0] LU_RELOAD = 3'(LOAD_USE_BUBBLES - 1);

    logic [0:0]       r_state;
    logic [2:0]       r_lu_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_mem_stall;
    logic w_hazard;
    logic w_flush;
    logic w_bubble;

    // Lowest stage index wins: iterate from oldest to youngest so the
    // youngest matching stage overwrites the select last.
    always_comb begin
        rs1mux_sel = '0;
        rs2mux_sel = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (load_regfile_fwd[k] && rd_fwd[k*REG_W +: REG_W] != '0) begin
                if (rd_fwd[k*REG_W +: REG_W] == rs1_id_ex)
                    rs1mux_sel = SEL_W'(k + 1);
                if (rd_fwd[k*REG_W +: REG_W] == rs2_id_ex)
                    rs2mux_sel = SEL_W'(k + 1);
            end
        end
    end

    assign w_mem_stall = (inst_mem_read & ~inst_mem_resp)
                       | ((data_mem_read | data_mem_write) & ~data_mem_resp);

    assign w_hazard = is_load_id_ex && (rd_id_ex != '0)
                   && ((uses_rs1_if_id && rd_id_ex == rs1_if_id)
                    || (uses_rs2_if_id && rd_id_ex == rs2_if_id));

    // A branch seen during a miss is replayed from PEND once it clears.
    assign w_flush  = ~w_mem_stall & (br_taken_ex | (r_state == S_PEND));
    assign w_bubble = ~w_mem_stall & ~w_flush
                    & ((r_lu_cnt != 3'd0) | w_hazard);

    // Controls are forced quiet while reset is held.
    assign stall_pc     = ~rst & (w_mem_stall | w_bubble);
    assign stall_if_id  = ~rst & (w_mem_stall | w_bubble);
    assign stall_id_ex  = ~rst & w_mem_stall;
    assign stall_ex_mem = ~rst & w_mem_stall;
    assign stall_mem_wb = ~rst & w_mem_stall;
    assign bubble_id_ex = ~rst & w_bubble;
    assign flush_if_id  = ~rst & w_flush;
    assign flush_id_ex  = ~rst & w_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
        end else if (r_state == S_RUN) begin
            if (br_taken_ex && w_mem_stall)
                r_state <= S_PEND;
        end else if (!w_mem_stall) begin
            r_state <= S_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lu_cnt <= 3'd0;
        end else if (w_flush) begin
            r_lu_cnt <= 3'd0;
        end else if (!w_mem_stall) begin
            if (r_lu_cnt != 3'd0)
                r_lu_cnt <= r_lu_cnt - 3'd1;
            else if (w_hazard)
                r_lu_cnt <= LU_RELOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (stat_clear) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_mem_stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_bubble && r_bubble_cnt != '1)
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            if (w_flush && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl with a scoreboard
// queue drained by an independent negedge monitor.
module tb_hazard_ctrl;

    localparam int NF = 3;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam int SW = $clog2(NF + 1);

    localparam logic [7:0] C_IDLE  = 8'b00000_0_00;
    localparam logic [7:0] C_STALL = 8'b11111_0_00;
    localparam logic [7:0] C_BUB   = 8'b11000_1_00;
    localparam logic [7:0] C_FLUSH = 8'b00000_0_11;

    localparam int F_RS1 = 0;
    localparam int F_RS2 = 1;
    localparam int F_CTL = 2;
    localparam int F_SC  = 3;
    localparam int F_BC  = 4;
    localparam int F_FC  = 5;

    logic clk = 1'b0;
    logic rst;
    logic [RW-1:0] rs1_id_ex, rs2_id_ex, rs1_if_id, rs2_if_id, rd_id_ex;
    logic uses_rs1_if_id, uses_rs2_if_id, is_load_id_ex;
    logic [NF*RW-1:0] rd_fwd;
    logic [NF-1:0] load_regfile_fwd;
    logic inst_mem_read, inst_mem_resp;
    logic data_mem_read, data_mem_write, data_mem_resp;
    logic br_taken_ex, stat_clear;
    logic [SW-1:0] rs1mux_sel, rs2mux_sel;
    logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic bubble_id_ex, flush_if_id, flush_id_ex;
    logic [CW-1:0] stall_cnt, bubble_cnt, flush_cnt;

    hazard_ctrl #(
        .NUM_FWD(NF), .REG_W(RW), .LOAD_USE_BUBBLES(3), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .rs1_id_ex(rs1_id_ex), .rs2_id_ex(rs2_id_ex),
        .rs1_if_id(rs1_if_id), .rs2_if_id(rs2_if_id),
        .uses_rs1_if_id(uses_rs1_if_id), .uses_rs2_if_id(uses_rs2_if_id),
        .rd_id_ex(rd_id_ex), .is_load_id_ex(is_load_id_ex),
        .rd_fwd(rd_fwd), .load_regfile_fwd(load_regfile_fwd),
        .inst_mem_read(inst_mem_read), .inst_mem_resp(inst_mem_resp),
        .data_mem_read(data_mem_read), .data_mem_write(data_mem_write),
        .data_mem_resp(data_mem_resp), .br_taken_ex(br_taken_ex),
        .stat_clear(stat_clear),
        .rs1mux_sel(rs1mux_sel), .rs2mux_sel(rs2mux_sel),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id),
        .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem),
        .stall_mem_wb(stall_mem_wb), .bubble_id_ex(bubble_id_ex),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         fld;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_bad = 0;

    task automatic expect_v(input string n, input int f, input logic [7:0] e);
        exp_t x;
        x.name = n;
        x.fld  = f;
        x.exp  = e;
        sb.push_back(x);
    endtask

    function automatic logic [7:0] actual(input int f);
        case (f)
            F_RS1:   return 8'(rs1mux_sel);
            F_RS2:   return 8'(rs2mux_sel);
            F_CTL:   return {stall_pc, stall_if_id, stall_id_ex,
                             stall_ex_mem, stall_mem_wb, bubble_id_ex,
                             flush_if_id, flush_id_ex};
            F_SC:    return 8'(stall_cnt);
            F_BC:    return 8'(bubble_cnt);
            default: return 8'(flush_cnt);
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [7:0] a;
            e = sb.pop_front();
            a = actual(e.fld);
            n_vec++;
            if (a !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", e.name, a, e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        rs1_id_ex = '0; rs2_id_ex = '0;
        rs1_if_id = '0; rs2_if_id = '0;
        uses_rs1_if_id = 1'b0; uses_rs2_if_id = 1'b0;
        rd_id_ex = '0; is_load_id_ex = 1'b0;
        rd_fwd = '0; load_regfile_fwd = '0;
        inst_mem_read = 1'b0; inst_mem_resp = 1'b0;
        data_mem_read = 1'b0; data_mem_write = 1'b0; data_mem_resp = 1'b0;
        br_taken_ex = 1'b0; stat_clear = 1'b0;
    endtask

    task automatic hazard_in();
        is_load_id_ex = 1'b1;
        rd_id_ex = 5'd7;
        uses_rs2_if_id = 1'b1;
        rs2_if_id = 5'd7;
    endtask

    task automatic do_clear();
        clear_in();
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        step();
        hazard_in();
        br_taken_ex = 1'b1;
        data_mem_read = 1'b1;
        expect_v("rst_ctl", F_CTL, C_IDLE);
        expect_v("rst_sc", F_SC, 8'd0);
        expect_v("rst_bc", F_BC, 8'd0);
        expect_v("rst_fc", F_FC, 8'd0);
        step();
        clear_in();
        rst = 1'b0;
        step();

        rs1_id_ex = 5'd5;
        rs2_id_ex = 5'd5;
        rd_fwd = {5'd5, 5'd5, 5'd5};
        load_regfile_fwd = 3'b111;
        expect_v("fwd_all", F_RS1, 8'd1);
        expect_v("fwd_ctl", F_CTL, C_IDLE);
        step();
        load_regfile_fwd = 3'b110;
        expect_v("fwd_skip0", F_RS1, 8'd2);
        step();
        load_regfile_fwd = 3'b100;
        expect_v("fwd_only2", F_RS2, 8'd3);
        step();
        load_regfile_fwd = 3'b111;
        rs1_id_ex = 5'd0;
        rd_fwd = {5'd5, 5'd5, 5'd0};
        expect_v("fwd_x0", F_RS1, 8'd0);
        expect_v("fwd_rs2", F_RS2, 8'd2);
        step();

        do_clear();
        hazard_in();
        expect_v("lu_b1", F_CTL, C_BUB);
        expect_v("lu_bc0", F_BC, 8'd0);
        step();
        clear_in();
        expect_v("lu_b2", F_CTL, C_BUB);
        step();
        expect_v("lu_b3", F_CTL, C_BUB);
        step();
        expect_v("lu_done", F_CTL, C_IDLE);
        expect_v("lu_bc3", F_BC, 8'd3);
        step();

        do_clear();
        hazard_in();
        expect_v("lum_b1", F_CTL, C_BUB);
        step();
        clear_in();
        inst_mem_read = 1'b1;
        expect_v("lum_s1", F_CTL, C_STALL);
        step();
        expect_v("lum_s2", F_CTL, C_STALL);
        step();
        inst_mem_read = 1'b0;
        expect_v("lum_b2", F_CTL, C_BUB);
        step();
        expect_v("lum_b3", F_CTL, C_BUB);
        step();
        expect_v("lum_done", F_CTL, C_IDLE);
        expect_v("lum_sc2", F_SC, 8'd2);
        expect_v("lum_bc3", F_BC, 8'd3);
        step();

        do_clear();
        data_mem_read = 1'b1;
        br_taken_ex = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_v("pend_stall", F_CTL, C_STALL);
            step();
        end
        clear_in();
        expect_v("pend_flush", F_CTL, C_FLUSH);
        step();
        expect_v("pend_after", F_CTL, C_IDLE);
        expect_v("pend_fc1", F_FC, 8'd1);
        expect_v("pend_sc4", F_SC, 8'd4);
        step();

        do_clear();
        hazard_in();
        br_taken_ex = 1'b1;
        expect_v("hzfl_flush", F_CTL, C_FLUSH);
        step();
        clear_in();
        expect_v("hzfl_after", F_CTL, C_IDLE);
        expect_v("hzfl_bc0", F_BC, 8'd0);
        expect_v("hzfl_fc1", F_FC, 8'd1);
        step();

        do_clear();
        data_mem_write = 1'b1;
        for (int i = 0; i < 20; i++) step();
        stat_clear = 1'b1;
        expect_v("sat_sc15", F_SC, 8'd15);
        expect_v("sat_ctl", F_CTL, C_STALL);
        step();
        clear_in();
        expect_v("sat_clr", F_SC, 8'd0);
        step();

        hazard_in();
        expect_v("rb_b1", F_CTL, C_BUB);
        step();
        clear_in();
        data_mem_read = 1'b1;
        br_taken_ex = 1'b1;
        rst = 1'b1;
        expect_v("rb_rst_ctl", F_CTL, C_IDLE);
        expect_v("rb_rst_bc", F_BC, 8'd0);
        step();
        clear_in();
        rst = 1'b0;
        expect_v("rb_after", F_CTL, C_IDLE);
        step();

        data_mem_read = 1'b1;
        br_taken_ex = 1'b1;
        expect_v("rp_stall", F_CTL, C_STALL);
        step();
        clear_in();
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_v("rp_noflush", F_CTL, C_IDLE);
        step();

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
